// File: rtl/tick_timer.sv
// ---------------------------------------------------------------------------
// tick_timer
//
// Programmable down-counting period timer driven by an external prescaler
// tick. A reload register sets the period (reload+1 ticks); each expiry
// raises a sticky irq, and an expiry that arrives while irq is still pending
// raises a sticky ovf. irq_ack clears both flags.
//
// Optional feature (macro TICK_TIMER_ONESHOT_EN):
//   Adds input port 'oneshot'. When oneshot=1 at expiry the timer raises irq,
//   parks cnt at 0 and returns to IDLE instead of reloading. Without the
//   macro the port is absent and the timer is always periodic.
//
// Priority inside one clock, highest first:
//   stop  > start  > tick (tick is only honoured in RUN with no start/stop)
//   wr_en is independent and only updates the reload register.
// ---------------------------------------------------------------------------
module tick_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             tick,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             start,
    input  logic             stop,
    input  logic             irq_ack,
`ifdef TICK_TIMER_ONESHOT_EN
    input  logic             oneshot,
`endif
    output logic [WIDTH-1:0] cnt,
    output logic             running,
    output logic             irq,
    output logic             ovf
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] reload;

    // Qualified count enable and expiry condition for this cycle.
    logic             count_en;
    logic             expire;
    logic             stop_on_expire;

    // Decode whether this cycle counts and whether it expires.
    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    always_comb begin
        count_en       = 1'b0;
        expire         = 1'b0;
        stop_on_expire = 1'b0;
        if (state == RUN && tick && !start && !stop) begin
            count_en = 1'b1;
            expire   = (cnt == '0);
        end
`ifdef TICK_TIMER_ONESHOT_EN
        stop_on_expire = expire && oneshot;
`endif
    end

    // Reload register: a write takes effect at the next load only.
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of its neighbours, which is what
    // makes a same-cycle start see the reload value from before the write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            reload <= '0;
        end else if (wr_en) begin
            reload <= wr_data;
        end
    end

    // Control FSM with registered cnt and running.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            running <= 1'b0;
        end else begin
            if (stop) begin
                // Stop freezes cnt where it is and wins over start.
                state   <= IDLE;
                running <= 1'b0;
            end else if (start) begin
                // Start or restart the period from the current reload.
                state   <= RUN;
                running <= 1'b1;
                cnt     <= reload;
            end else if (count_en) begin
                if (!expire) begin
                    cnt <= cnt - 1'b1;
                end else if (stop_on_expire) begin
                    state   <= IDLE;
                    running <= 1'b0;
                    cnt     <= '0;
                end else begin
                    cnt <= reload;
                end
            end
        end
    end

    // Sticky irq: expiry sets it and wins over a simultaneous acknowledge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            irq <= 1'b0;
        end else if (expire) begin
            irq <= 1'b1;
        end else if (irq_ack) begin
            irq <= 1'b0;
        end
    end

    // Sticky ovf: an expiry lost because irq was still pending; the
    // acknowledge wins here so ack+expiry leaves a clean irq without ovf.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf <= 1'b0;
        end else if (irq_ack) begin
            ovf <= 1'b0;
        end else if (expire && irq) begin
            ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tick_timer.sv
// ---------------------------------------------------------------------------
// tb_tick_timer
//
// Directed self-checking bench for tick_timer (WIDTH=8). Inputs change on the
// falling edge and outputs are sampled on the following falling edge, i.e.
// half a clock after the rising edge that acted on them.
// Define TICK_TIMER_ONESHOT_EN for both bench and RTL to add the one-shot case.
// ---------------------------------------------------------------------------
module tb_tick_timer;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rstn;
    logic             tick;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             start;
    logic             stop;
    logic             irq_ack;
    logic             oneshot;
    logic [WIDTH-1:0] cnt;
    logic             running;
    logic             irq;
    logic             ovf;

    int n_checks = 0;
    int n_pass   = 0;

    tick_timer #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .tick    (tick),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .start   (start),
        .stop    (stop),
        .irq_ack (irq_ack),
`ifdef TICK_TIMER_ONESHOT_EN
        .oneshot (oneshot),
`endif
        .cnt     (cnt),
        .running (running),
        .irq     (irq),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock: inputs already set are sampled at the rising edge,
    // then all pulses drop and we return at the next falling edge.
    task automatic step();
        @(negedge clk);
        tick    = 1'b0;
        wr_en   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        irq_ack = 1'b0;
    endtask

    task automatic do_write(input logic [WIDTH-1:0] v);
        wr_en   = 1'b1;
        wr_data = v;
        step();
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_all(input string tag, input int c, input bit r, input bit i, input bit o);
        check({tag, ".cnt"},     cnt,     c);
        check({tag, ".running"}, running, r);
        check({tag, ".irq"},     irq,     i);
        check({tag, ".ovf"},     ovf,     o);
    endtask

    initial begin
        int exp_seq[4];
        rstn    = 1'b0;
        tick    = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        start   = 1'b0;
        stop    = 1'b0;
        irq_ack = 1'b0;
        oneshot = 1'b0;

        // Reset state
        idle(2);
        check_all("reset", 0, 0, 0, 0);
        rstn = 1'b1;
        step();
        check_all("post_reset", 0, 0, 0, 0);

        // Basic period: reload=3, tick every 4 clk
        do_write(8'd3);
        check("write_no_cnt_change", cnt, 0);
        start = 1'b1;
        step();
        check_all("start3", 3, 1, 0, 0);
        exp_seq = '{2, 1, 0, 3};
        for (int k = 0; k < 4; k++) begin
            do_tick();
            check($sformatf("period3.t%0d.cnt", k + 1), cnt, exp_seq[k]);
            check($sformatf("period3.t%0d.irq", k + 1), irq, (k == 3));
            idle(3);
        end
        check_all("period3.end", 3, 1, 1, 0);
        irq_ack = 1'b1;
        step();
        check_all("ack1", 3, 1, 0, 0);

        // reload=0: expire every tick, then overflow, then ack
        do_write(8'd0);
        check("write0_keeps_cnt", cnt, 3);
        start = 1'b1;
        step();
        check_all("start0", 0, 1, 0, 0);
        do_tick();
        check_all("r0.t1", 0, 1, 1, 0);
        do_tick();
        check_all("r0.t2_ovf", 0, 1, 1, 1);
        irq_ack = 1'b1;
        step();
        check_all("r0.ack", 0, 1, 0, 0);

        // Expiry and ack in the same cycle: irq set wins, ovf stays 0
        do_tick();
        check_all("r0.t3", 0, 1, 1, 0);
        tick    = 1'b1;
        irq_ack = 1'b1;
        step();
        check_all("ack_and_expire", 0, 1, 1, 0);
        irq_ack = 1'b1;
        step();
        check_all("ack2", 0, 1, 0, 0);

        // Start sees pre-write reload; start+stop -> stop wins, cnt held
        do_write(8'd5);
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'd9;
        step();
        check_all("start_old_reload", 5, 1, 0, 0);
        start = 1'b1;
        stop  = 1'b1;
        step();
        check_all("start_stop", 5, 0, 0, 0);
        do_tick();
        check_all("idle_tick", 5, 0, 0, 0);

        // Tick ignored when start is asserted in RUN (restart only)
        start = 1'b1;
        step();
        check("restart9", cnt, 9);
        do_tick();
        check("run9_t1", cnt, 8);
        start = 1'b1;
        tick  = 1'b1;
        step();
        check("start_blocks_tick", cnt, 9);

        // Reload changed mid-period, then reset mid-RUN
        do_write(8'd7);
        start = 1'b1;
        step();
        check("start7", cnt, 7);
        for (int k = 0; k < 5; k++) do_tick();
        check("run7_at2", cnt, 2);
        do_write(8'd1);
        check("midrun_write_keeps_cnt", cnt, 2);
        do_tick();
        check("new.t1", cnt, 1);
        do_tick();
        check("new.t2", cnt, 0);
        do_tick();
        check_all("new.expire_reload1", 1, 1, 1, 0);
        do_tick();
        check_all("new.t4", 0, 1, 1, 0);
        #1 rstn = 1'b0;
        #1;
        check_all("async_reset", 0, 0, 0, 0);
        step();
        rstn = 1'b1;
        step();
        do_tick();
        check_all("after_reset_idle", 0, 0, 0, 0);

`ifdef TICK_TIMER_ONESHOT_EN
        // One-shot: reload=2, three ticks then park in IDLE at 0
        oneshot = 1'b1;
        do_write(8'd2);
        start = 1'b1;
        step();
        check_all("os.start", 2, 1, 0, 0);
        do_tick();
        do_tick();
        check("os.t2", cnt, 0);
        do_tick();
        check_all("os.expire", 0, 0, 1, 0);
        do_tick();
        do_tick();
        check_all("os.more_ticks", 0, 0, 1, 0);
        oneshot = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Absolute bound so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/tick_timer.md
TICK_TIMER -- requirements
Module: tick_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the width of the reload register and down-counter.
REQ-002 SHALL have clk, input, 1 bit, the clock; all state changes on its rising edge.
REQ-003 SHALL have rstn, input, 1 bit, the reset: asynchronous, active-low.
REQ-004 SHALL have tick, input, 1 bit, a one-clk-wide pulse from the upstream prescaler counter on each wrap; it is the timer's count enable.
REQ-005 SHALL have wr_en, input, 1 bit, which writes wr_data into the reload register.
REQ-006 SHALL have wr_data, input, WIDTH bits, the reload value.
REQ-007 SHALL have start, input, 1 bit, a start/restart request.
REQ-008 SHALL have stop, input, 1 bit, a stop request.
REQ-009 SHALL have irq_ack, input, 1 bit, which clears irq and ovf.
REQ-010 SHALL have cnt, output, WIDTH bits, the current down-counter value.
REQ-011 SHALL have running, output, 1 bit, which is high exactly when the state is RUN.
REQ-012 SHALL have irq, output, 1 bit, a sticky expiry flag.
REQ-013 SHALL have ovf, output, 1 bit, a sticky flag marking an expiry lost while irq was still pending.

Function
REQ-014 SHALL implement a state machine with states IDLE and RUN.
REQ-015 SHALL, on wr_en, load reload <= wr_data at the next edge in any state; the new value takes effect at the next load and does not alter cnt.
REQ-016 SHALL, on start in IDLE or RUN, set cnt <= reload (the value before any same-cycle write) and enter RUN; in RUN this restarts the period.
REQ-017 SHALL, on stop, enter IDLE with cnt held; stop SHALL win over a simultaneous start.
REQ-018 SHALL, in RUN with tick=1 and no start/stop: if cnt != 0, decrement cnt by 1; if cnt == 0, expire.
REQ-019 SHALL, on expiry, set cnt <= reload and set irq <= 1.
REQ-020 SHALL give a period of exactly reload+1 ticks; reload == 0 SHALL expire on every tick.
REQ-021 SHALL ignore tick in IDLE and SHALL ignore tick in a cycle where start or stop is asserted.
REQ-022 SHALL, if expiry occurs while irq is already 1, set ovf <= 1.
REQ-023 SHALL, on irq_ack, clear irq and ovf; on simultaneous irq_ack and expiry, set irq = 1 and leave ovf = 0 (set wins for irq).
REQ-024 SHALL make every output registered; irq SHALL rise on the edge after the expiring tick is sampled (latency 1 clk).
REQ-025 SHALL keep cnt arithmetic modulo 2^WIDTH with no underflow past 0, because expiry intercepts 0.

Reset
REQ-026 SHALL, while rstn=0, asynchronously force state=IDLE, reload=0, cnt=0, irq=0, ovf=0, running=0.
REQ-027 SHALL abandon any period in progress on reset mid-RUN; after release the timer stays IDLE until start.

Configuration
REQ-028 SHALL use the macro TICK_TIMER_ONESHOT_EN; when it is defined, add input port oneshot (1 bit).
REQ-029 SHALL, with TICK_TIMER_ONESHOT_EN defined and oneshot=1 at expiry, set irq, set cnt <= 0 and enter IDLE instead of reloading; with oneshot=0, behave periodically.
REQ-030 SHALL, without TICK_TIMER_ONESHOT_EN, omit the oneshot port and always operate periodically.

Verification
REQ-031 SHALL cover: write 3, start, tick every 4 clk -> cnt 3,2,1,0 then irq=1 on the 4th tick, cnt=3, running=1.
REQ-032 SHALL cover: reload=0, start, tick every cycle -> irq asserted on the 1st tick; second expiry without ack -> ovf=1; irq_ack -> irq=0, ovf=0.
REQ-033 SHALL cover: expiry and irq_ack in the same cycle -> irq=1, ovf=0.
REQ-034 SHALL cover: start and stop together in RUN with cnt=5 -> IDLE, running=0, cnt=5; a following tick -> cnt stays 5.
REQ-035 SHALL cover: reload=7, RUN at cnt=2, wr_en with wr_data=1, then ticks -> 1,0, expiry reloads 1; rstn pulsed mid-RUN -> all outputs 0, IDLE.
REQ-036 SHALL cover, with TICK_TIMER_ONESHOT_EN and oneshot=1, reload=2: 3 ticks -> irq=1, cnt=0, running=0; further ticks -> no change.
